zig_zag_pp: RTL and testbench

ZIG_ZAG_PP -- requirements
Module: zig_zag_pp

---
 rtl/zig_zag_pp_if.sv | 15 +
 rtl/zig_zag_pp.sv | 127 ++++++++++++
 tb/tb_zig_zag_pp.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/zig_zag_pp_if.sv
// AXI4-Stream bundle shared by the coefficient input and the reordered output.
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic                    tuser;

  modport master (output tdata, tstrb, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tstrb, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/zig_zag_pp.sv
// Ping-pong 8x8 zigzag reorderer: each block is scattered into one of two banks
// on write and streamed out sequentially while the other bank fills.
module zig_zag_pp #(
  parameter int DCT_WIDTH   = 12,
  parameter bit DIR_DEFAULT = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          dir_i,
  axi4_stream_if.slave  dct_i,
  axi4_stream_if.master zz_o,
  output logic          busy_o
);
  localparam int TDATA_WIDTH = ((DCT_WIDTH + 7) / 8) * 8;

  typedef enum logic [1:0] {EMPTY, FILL, FULL, DRAIN} bank_state_t;

  // ZZ[k] is the raster position of zigzag rank k; ZZ_INV is its inverse.
  localparam int ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
  localparam int ZZ_INV [64] = '{
     0,  1,  5,  6, 14, 15, 27, 28,  2,  4,  7, 13, 16, 26, 29, 42,
     3,  8, 12, 17, 25, 30, 41, 43,  9, 11, 18, 24, 31, 40, 44, 53,
    10, 19, 23, 32, 39, 45, 52, 54, 20, 22, 33, 38, 46, 51, 55, 60,
    21, 34, 37, 47, 50, 56, 59, 61, 35, 36, 48, 49, 57, 58, 62, 63};

  bank_state_t          state [2];
  logic [1:0]           dir_flag;
  logic [1:0]           user_flag;
  logic [1:0]           last_flag;
  logic                 wp;
  logic                 rp;
  logic [5:0]           wc;
  logic [5:0]           rc;
  logic [DCT_WIDTH-1:0] mem [128];
  logic [DCT_WIDTH-1:0] rd_data;

  logic       in_ready;
  logic       in_hs;
  logic       first_beat;
  logic       blk_dir;
  logic [5:0] waddr;
  logic       out_valid;
  logic       out_hs;
  logic [5:0] raddr;
  logic       rbank;
  logic       unused_sideband;

  assign in_ready   = !rst_i && (state[wp] == EMPTY || state[wp] == FILL);
  assign in_hs      = in_ready && dct_i.tvalid;
  assign first_beat = (state[wp] == EMPTY);
  assign blk_dir    = first_beat ? dir_i : dir_flag[wp];
  assign waddr      = blk_dir ? 6'(ZZ[wc]) : 6'(ZZ_INV[wc]);

  assign out_valid  = (state[rp] == FULL || state[rp] == DRAIN);
  assign out_hs     = out_valid && zz_o.tready;
  // Read one beat ahead so the output register already holds the next address.
  assign raddr      = out_hs ? rc + 6'd1 : rc;
  assign rbank      = (out_hs && rc == 6'd63) ? ~rp : rp;

  always_ff @(posedge clk_i) begin
    if (in_hs) begin
      mem[{wp, waddr}] <= dct_i.tdata[DCT_WIDTH-1:0];
    end
    rd_data <= mem[{rbank, raddr}];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state[0]  <= EMPTY;
      state[1]  <= EMPTY;
      wp        <= 1'b0;
      rp        <= 1'b0;
      wc        <= 6'd0;
      rc        <= 6'd0;
      dir_flag  <= {2{DIR_DEFAULT}};
      user_flag <= 2'b00;
      last_flag <= 2'b00;
    end else begin
      if (in_hs) begin
        if (first_beat) begin
          dir_flag[wp]  <= dir_i;
          user_flag[wp] <= dct_i.tuser;
          last_flag[wp] <= dct_i.tlast;
        end else begin
          user_flag[wp] <= user_flag[wp] | dct_i.tuser;
          last_flag[wp] <= last_flag[wp] | dct_i.tlast;
        end
        if (wc == 6'd63) begin
          state[wp] <= FULL;
          wp        <= ~wp;
          wc        <= 6'd0;
        end else begin
          state[wp] <= FILL;
          wc        <= wc + 6'd1;
        end
      end
      // Write and read never target the same bank in one cycle: their states are disjoint.
      if (out_hs && rc == 6'd63) begin
        state[rp] <= EMPTY;
        rp        <= ~rp;
        rc        <= 6'd0;
      end else begin
        if (out_hs) begin
          rc <= rc + 6'd1;
        end
        if (state[rp] == FULL) begin
          state[rp] <= DRAIN;
        end
      end
    end
  end

  assign dct_i.tready = in_ready;
  assign zz_o.tvalid  = out_valid;
  assign zz_o.tdata   = out_valid ? TDATA_WIDTH'($signed(rd_data)) : '0;
  assign zz_o.tuser   = out_valid && (rc == 6'd0) && user_flag[rp];
  assign zz_o.tlast   = out_valid && (rc == 6'd63) && last_flag[rp];
  assign zz_o.tstrb   = '1;
  assign zz_o.tkeep   = '1;
  assign busy_o       = (state[0] != EMPTY) || (state[1] != EMPTY);

  assign unused_sideband = ^{dct_i.tdata, dct_i.tstrb, dct_i.tkeep};
endmodule

// File: tb/tb_zig_zag_pp.sv
// Directed bench for zig_zag_pp: forward/inverse ordering, throughput,
// backpressure, sign extension and mid-block reset.
module tb_zig_zag_pp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dir = 1'b0;
  logic busy;
  always #5 clk = ~clk;

  axi4_stream_if #(.DATA_WIDTH(16)) dct_if ();
  axi4_stream_if #(.DATA_WIDTH(16)) zz_if ();

  zig_zag_pp #(.DCT_WIDTH(12), .DIR_DEFAULT(1'b0)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .dir_i (dir),
    .dct_i (dct_if),
    .zz_o  (zz_if),
    .busy_o(busy)
  );

  int zz [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
  int zzinv [64];

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  logic [15:0] oq_data [$];
  logic        oq_user [$];
  logic        oq_last [$];
  int          oq_cyc  [$];
  int          iq_cyc  [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (zz_if.tvalid && zz_if.tready) begin
        oq_data.push_back(zz_if.tdata);
        oq_user.push_back(zz_if.tuser);
        oq_last.push_back(zz_if.tlast);
        oq_cyc.push_back(cyc);
      end
      if (dct_if.tvalid && dct_if.tready) iq_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    oq_data.delete(); oq_user.delete(); oq_last.delete(); oq_cyc.delete(); iq_cyc.delete();
  endtask

  task automatic send_beat(input logic [15:0] d, input logic u, input logic l);
    int n;
    dct_if.tdata  = d;
    dct_if.tuser  = u;
    dct_if.tlast  = l;
    dct_if.tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!dct_if.tready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("in_ready_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic d, input int base, input int user_beat,
                            input int last_beat, input int nbeats);
    dir = d;
    for (int k = 0; k < nbeats; k++)
      send_beat(16'(base + k), k == user_beat, k == last_beat);
  endtask

  task automatic idle_in();
    dct_if.tvalid = 1'b0;
    dct_if.tuser  = 1'b0;
    dct_if.tlast  = 1'b0;
  endtask

  task automatic wait_out(input int n, input string tag);
    int t;
    t = 0;
    while (oq_data.size() < n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(oq_data.size()), 32'(n));
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic check_block(input int off, input logic d, input int base,
                             input logic u, input logic l, input string nm);
    for (int k = 0; k < 64; k++) begin
      int e;
      e = base + (d ? zzinv[k] : zz[k]);
      chk($sformatf("%s_k%0d_data", nm, k), 32'(oq_data[off+k]), 32'(e));
      chk($sformatf("%s_k%0d_user", nm, k), 32'(oq_user[off+k]), 32'(u && k == 0));
      chk($sformatf("%s_k%0d_last", nm, k), 32'(oq_last[off+k]), 32'(l && k == 63));
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_in_tready"}, 32'(dct_if.tready), 32'd0);
    chk({nm, "_tvalid"}, 32'(zz_if.tvalid), 32'd0);
    chk({nm, "_tuser"}, 32'(zz_if.tuser), 32'd0);
    chk({nm, "_tlast"}, 32'(zz_if.tlast), 32'd0);
    chk({nm, "_tdata"}, 32'(zz_if.tdata), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int gaps;
    for (int k = 0; k < 64; k++) zzinv[zz[k]] = k;
    dct_if.tdata = '0; dct_if.tstrb = '1; dct_if.tkeep = '1;
    idle_in();
    zz_if.tready = 1'b1;

    // Reset values, then tready in the first cycle after release.
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    align();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_tready", 32'(dct_if.tready), 32'd1);
    chk("strb_ones", 32'(zz_if.tstrb), 32'h3);
    chk("keep_ones", 32'(zz_if.tkeep), 32'h3);

    // Forward: raster in, zigzag out, tuser on beat 0.
    clear_q();
    align();
    send_block(1'b0, 0, 0, 63, 64);
    idle_in();
    wait_out(64, "fwd_count");
    chk("fwd_latency", 32'(oq_cyc[0]), 32'(iq_cyc[63] + 1));
    check_block(0, 1'b0, 0, 1'b1, 1'b1, "fwd");
    wait_idle("fwd_idle");

    // Inverse: tlast only on beat 20 still frames 64 beats and shows on output 63.
    clear_q();
    align();
    send_block(1'b1, 0, -1, 20, 64);
    idle_in();
    wait_out(64, "inv_count");
    check_block(0, 1'b1, 0, 1'b0, 1'b1, "inv");
    wait_idle("inv_idle");

    // Sign extension with junk in the upper input bits.
    clear_q();
    align();
    dir = 1'b0;
    send_beat(16'hAF80, 1'b0, 1'b0);
    for (int k = 1; k < 64; k++) send_beat(16'(k), 1'b0, k == 63);
    idle_in();
    wait_out(64, "sext_count");
    chk("sext_beat0", 32'(oq_data[0]), 32'h0000FF80);
    chk("sext_beat1", 32'(oq_data[1]), 32'd1);
    chk("sext_beat2", 32'(oq_data[2]), 32'd8);
    wait_idle("sext_idle");

    // Four blocks back to back, direction alternating per block.
    clear_q();
    align();
    for (int b = 0; b < 4; b++) send_block(1'(b % 2), 64 * b, 0, 63, 64);
    idle_in();
    wait_out(256, "tput_count");
    chk("tput_latency", 32'(oq_cyc[0]), 32'(iq_cyc[63] + 1));
    gaps = 0;
    for (int i = 1; i < 256; i++) begin
      if (oq_cyc[i] != oq_cyc[0] + i) gaps++;
      if (iq_cyc[i] != iq_cyc[0] + i) gaps++;
    end
    chk("tput_no_gap", 32'(gaps), 32'd0);
    for (int b = 0; b < 4; b++)
      check_block(64 * b, 1'(b % 2), 64 * b, 1'b1, 1'b1, $sformatf("tput_b%0d", b));
    wait_idle("tput_idle");

    // Backpressure: two blocks fill both banks, third must stall.
    clear_q();
    zz_if.tready = 1'b0;
    align();
    send_block(1'b0, 0, 0, 63, 64);
    send_block(1'b1, 64, -1, 63, 64);
    dir = 1'b0;
    dct_if.tdata = 16'd128; dct_if.tuser = 1'b1; dct_if.tlast = 1'b0; dct_if.tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_in_tready_%0d", i), 32'(dct_if.tready), 32'd0);
      chk($sformatf("bp_tvalid_%0d", i), 32'(zz_if.tvalid), 32'd1);
      chk($sformatf("bp_tdata_%0d", i), 32'(zz_if.tdata), 32'd0);
      chk($sformatf("bp_tuser_%0d", i), 32'(zz_if.tuser), 32'd1);
      chk($sformatf("bp_tlast_%0d", i), 32'(zz_if.tlast), 32'd0);
    end
    chk("bp_busy", 32'(busy), 32'd1);
    zz_if.tready = 1'b1;
    align();
    send_block(1'b0, 128, 0, 63, 64);
    idle_in();
    wait_out(192, "bp_count");
    check_block(0, 1'b0, 0, 1'b1, 1'b1, "bp_b0");
    check_block(64, 1'b1, 64, 1'b0, 1'b1, "bp_b1");
    check_block(128, 1'b0, 128, 1'b1, 1'b1, "bp_b2");
    wait_idle("bp_idle");

    // Reset after 30 beats discards the partial block and its sideband.
    align();
    send_block(1'b1, 500, 0, 5, 30);
    idle_in();
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    align();
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("mid_rst");
    align();
    align();
    rst = 1'b0;
    clear_q();
    @(negedge clk);
    chk("mid_release_tready", 32'(dct_if.tready), 32'd1);
    chk("mid_release_busy", 32'(busy), 32'd0);
    align();
    send_block(1'b0, 200, -1, 63, 64);
    idle_in();
    wait_out(64, "mid_count");
    check_block(0, 1'b0, 200, 1'b0, 1'b1, "mid_clean");
    wait_idle("mid_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
